// File: rtl/rptr_empty.sv
// -----------------------------------------------------------------------------
// rptr_empty
// Read-side pointer and empty-flag control for a dual-clock asynchronous FIFO.
// Everything here runs in the read clock domain.
//
// The Gray write pointer from the write domain passes through a two-flop
// synchronizer before any use. The read pointer is kept in binary (for the RAM
// address) and in Gray (for the write domain to synchronize). The empty flag is
// registered and conservative: it may stay set a little longer than the true
// occupancy, but it never clears while the FIFO is really empty.
//
// Optional build macro: FIFO_RD_LEVEL_EN
//   Adds the registered fill level (rlevel) and almost-empty flag (raempty).
//   Without the macro these ports and all of their logic are absent.
//
// Parameters
//   ASIZE     : address width, FIFO depth = 2**ASIZE, pointers are ASIZE+1 bits
//   AEMPTY_TH : almost-empty threshold in entries (level option only)
//
// Ports
//   rclk    in   1        read clock, all flops on its rising edge
//   rrst    in   1        asynchronous active-high reset
//   rinc    in   1        pop request, honoured only while rempty is low
//   wptr    in   ASIZE+1  Gray write pointer, asynchronous to rclk
//   raddr   out  ASIZE    RAM read address, low bits of the binary read pointer
//   rptr    out  ASIZE+1  registered Gray read pointer for the write domain
//   rempty  out  1        registered empty flag
//   rlevel  out  ASIZE+1  registered fill level          (FIFO_RD_LEVEL_EN)
//   raempty out  1        registered almost-empty flag   (FIFO_RD_LEVEL_EN)
// -----------------------------------------------------------------------------
module rptr_empty #(
    parameter int ASIZE     = 4,
    parameter int AEMPTY_TH = 2
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rinc,
    input  logic [ASIZE:0]   wptr,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ASIZE:0]   rlevel,
    output logic             raempty
`endif
);

    localparam int PW = ASIZE + 1;

    // Binary to reflected-binary Gray code.
    function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

`ifdef FIFO_RD_LEVEL_EN
    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    localparam logic [ASIZE:0] AEMPTY_TH_W = PW'(AEMPTY_TH);
`endif

    // Synchronizer stages, kept free of any logic between wptr and the first flop.
    logic [ASIZE:0] rq1_wptr_r;
    logic [ASIZE:0] rq2_wptr_r;

    // Read pointer state.
    logic [ASIZE:0] rbin_r;
    logic [ASIZE:0] rptr_r;
    logic           rempty_r;

    // Next-state values.
    logic           pop_s;
    logic [ASIZE:0] rbinnext_s;
    logic [ASIZE:0] rgraynext_s;
    logic           rempty_next_s;

    // Two-flop synchronizer bringing the Gray write pointer into rclk.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rq1_wptr_r <= {PW{1'b0}};
            rq2_wptr_r <= {PW{1'b0}};
        end else begin
            rq1_wptr_r <= wptr;
            rq2_wptr_r <= rq1_wptr_r;
        end
    end

    // Next read pointer and empty decision.
    always_comb begin
        pop_s         = 1'b0;
        rbinnext_s    = rbin_r;
        rgraynext_s   = {PW{1'b0}};
        rempty_next_s = 1'b1;

        // A request against an empty FIFO is dropped, so the pointers hold.
        pop_s       = rinc & ~rempty_r;
        rbinnext_s  = rbin_r + {{ASIZE{1'b0}}, pop_s};
        rgraynext_s = bin2gray(rbinnext_s);
        // Comparing the pointer we are about to hold lets the pop of the last
        // entry raise rempty on that same edge. All ASIZE+1 bits must match,
        // so a full FIFO (same index, other lap) never looks empty.
        rempty_next_s = (rgraynext_s == rq2_wptr_r);
    end

    // Pointer and empty-flag registers.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin_r   <= {PW{1'b0}};
            rptr_r   <= {PW{1'b0}};
            rempty_r <= 1'b1;
        end else begin
            rbin_r   <= rbinnext_s;
            rptr_r   <= rgraynext_s;
            rempty_r <= rempty_next_s;
        end
    end

    // Outputs come straight from flops; rptr in particular is crossed into the
    // write domain and must not glitch.
    assign raddr  = rbin_r[ASIZE-1:0];
    assign rptr   = rptr_r;
    assign rempty = rempty_r;

`ifdef FIFO_RD_LEVEL_EN
    logic [ASIZE:0] rwbin_s;
    logic [ASIZE:0] rlevel_next_s;
    logic           raempty_next_s;
    logic [ASIZE:0] rlevel_r;
    logic           raempty_r;

    // Fill level as seen from the read side, against the synchronized writer.
    always_comb begin
        rwbin_s        = {PW{1'b0}};
        rlevel_next_s  = {PW{1'b0}};
        raempty_next_s = 1'b1;

        rwbin_s = gray2bin(rq2_wptr_r);
        // Modulo subtraction across the lap bit yields 2**ASIZE when full.
        rlevel_next_s  = rwbin_s - rbinnext_s;
        raempty_next_s = (rlevel_next_s <= AEMPTY_TH_W);
    end

    // Level and almost-empty registers.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rlevel_r  <= {PW{1'b0}};
            raempty_r <= 1'b1;
        end else begin
            rlevel_r  <= rlevel_next_s;
            raempty_r <= raempty_next_s;
        end
    end

    assign rlevel  = rlevel_r;
    assign raempty = raempty_r;
`endif

endmodule
